// File: rtl/audio_dma_reader.sv
// Audio sample-DMA channel: fetches PCM bytes over the shared req/gnt bus and plays them as nibbles.
// Optional feature macro AUDIO_DMA_LOOP_EN: at the natural end of a block, reload it and keep playing.
module audio_dma_reader #(
  parameter int unsigned BASE_DIV   = 256,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_length,
  input  logic [7:0]  dma_ctrl,
  input  logic        trig_wr,
  input  logic [7:0]  trig_din,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [15:0] bus_addr,
  output logic [2:0]  bus_bank,
  input  logic [7:0]  bus_din,
  output logic [3:0]  sample,
  output logic        sample_stb,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W   = $clog2(BASE_DIV * 8);
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W  = PTR_W + 1;
  localparam int unsigned BYTES_W = 13;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAPTURE, S_PLAY_ONLY} state_e;

  state_e              state_q, state_d;
  logic [15:0]         addr_q, addr_d;
  logic [BYTES_W-1:0]  bytes_left_q, bytes_left_d;
  logic [2:0]          bank_q, bank_d;
  logic [1:0]          rate_q, rate_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                phase_q, phase_d;
  logic [3:0]          hold_q, hold_d;
  logic [3:0]          sample_q, sample_d;
  logic                stb_q, stb_d;
  logic                bus_req_q, bus_req_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [7:0]          fifo_q [FIFO_DEPTH];
`ifdef AUDIO_DMA_LOOP_EN
  logic [15:0]         start_addr_q;
  logic [BYTES_W-1:0]  start_bytes_q;
`endif

  logic               start_c, stop_c, run_c, tick_c, hi_tick_c, lo_tick_c;
  logic               pop_c, push_c, end_c, fetch_ok_c;
  logic [7:0]         fifo_rd_c;
  logic [BYTES_W-1:0] start_bytes_c;
  logic               unused_ok_c;

  function automatic logic [CNT_W-1:0] reload_f(input logic [1:0] rate);
    return CNT_W'((BASE_DIV << rate) - 32'd1);
  endfunction

  // Length register counts 16-byte units; zero selects the full 4 KiB block.
  assign start_bytes_c = (dma_length == 8'd0) ? BYTES_W'(13'h1000)
                                              : {1'b0, dma_length, 4'h0};

  assign start_c    = trig_wr & trig_din[7] & dma_ctrl[7];
  assign stop_c     = busy_q & ((trig_wr & ~trig_din[7]) | ~dma_ctrl[7]);
  assign run_c      = busy_q & ~start_c & ~stop_c;
  assign tick_c     = run_c & (cnt_q == '0);
  assign hi_tick_c  = tick_c & ~phase_q;
  assign lo_tick_c  = tick_c & phase_q;
  assign pop_c      = hi_tick_c & (fcnt_q != '0);
  assign push_c     = run_c & (state_q == S_CAPTURE);
  assign end_c      = lo_tick_c & (bytes_left_q == '0) & (fcnt_q == '0);
  assign fifo_rd_c  = fifo_q[rd_ptr_q];
  assign fetch_ok_c = (fcnt_d < FCNT_W'(FIFO_DEPTH)) & (bytes_left_d != '0);
  assign unused_ok_c = ^{dma_ctrl[3:2], trig_din[6:0]};

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: restart beats stop beats natural end
  always_comb begin
    state_d = state_q;
    if (start_c) begin
      state_d = S_REQ;
    end else if (stop_c) begin
      state_d = S_IDLE;
    end else if (end_c) begin
`ifdef AUDIO_DMA_LOOP_EN
      state_d = S_REQ;
`else
      state_d = S_IDLE;
`endif
    end else begin
      case (state_q)
        S_REQ:       if (bus_gnt) state_d = S_CAPTURE;
        S_CAPTURE,
        S_PLAY_ONLY: state_d = fetch_ok_c ? S_REQ : S_PLAY_ONLY;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs, registered below
  always_comb begin
    bus_req_d = (state_d == S_REQ);
    busy_d    = (state_d != S_IDLE);
    done_d    = end_c;
  end

  // Datapath next state: address/count, prefetch FIFO, rate counter, nibble sequencing
  always_comb begin
    addr_d       = addr_q;
    bytes_left_d = bytes_left_q;
    bank_d       = bank_q;
    rate_d       = rate_q;
    cnt_d        = cnt_q;
    fcnt_d       = fcnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    phase_d      = phase_q;
    hold_d       = hold_q;
    sample_d     = sample_q;
    stb_d        = 1'b0;
    if (start_c) begin
      addr_d       = dma_addr;
      bytes_left_d = start_bytes_c;
      bank_d       = dma_ctrl[6:4];
      rate_d       = dma_ctrl[1:0];
      cnt_d        = reload_f(dma_ctrl[1:0]);
      fcnt_d       = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      phase_d      = 1'b0;
    end else if (run_c) begin
      if (push_c) begin
        addr_d       = addr_q + 16'd1;
        bytes_left_d = bytes_left_q - BYTES_W'(1);
        wr_ptr_d     = wr_ptr_q + PTR_W'(1);
      end
      fcnt_d = fcnt_q + FCNT_W'(push_c) - FCNT_W'(pop_c);
      cnt_d  = tick_c ? reload_f(rate_q) : cnt_q - CNT_W'(1);
      // An empty FIFO at a high-nibble tick leaves sample and phase untouched
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        sample_d = fifo_rd_c[7:4];
        hold_d   = fifo_rd_c[3:0];
        phase_d  = 1'b1;
        stb_d    = 1'b1;
      end
      if (lo_tick_c) begin
        sample_d = hold_q;
        phase_d  = 1'b0;
        stb_d    = 1'b1;
      end
`ifdef AUDIO_DMA_LOOP_EN
      if (end_c) begin
        addr_d       = start_addr_q;
        bytes_left_d = start_bytes_q;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      bytes_left_q <= '0;
      bank_q       <= '0;
      rate_q       <= '0;
      cnt_q        <= '0;
      fcnt_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      phase_q      <= 1'b0;
      hold_q       <= '0;
      sample_q     <= '0;
      stb_q        <= 1'b0;
      bus_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      bytes_left_q <= bytes_left_d;
      bank_q       <= bank_d;
      rate_q       <= rate_d;
      cnt_q        <= cnt_d;
      fcnt_q       <= fcnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      phase_q      <= phase_d;
      hold_q       <= hold_d;
      sample_q     <= sample_d;
      stb_q        <= stb_d;
      bus_req_q    <= bus_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) fifo_q[wr_ptr_q] <= bus_din;
  end

`ifdef AUDIO_DMA_LOOP_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      start_addr_q  <= '0;
      start_bytes_q <= '0;
    end else if (start_c) begin
      start_addr_q  <= dma_addr;
      start_bytes_q <= start_bytes_c;
    end
  end
`endif

  assign bus_req    = bus_req_q;
  assign bus_addr   = addr_q;
  assign bus_bank   = bank_q;
  assign sample     = sample_q;
  assign sample_stb = stb_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_audio_dma_reader.sv
// Directed self-checking bench for audio_dma_reader: playback order, rate, bank, wrap,
// underrun, restart, stop and reset behaviour against a synthetic ROM image.
`timescale 1ns/1ps
module tb_audio_dma_reader;

  localparam int unsigned BASE_DIV = 4;
  localparam int PER0 = BASE_DIV;
  localparam int PER3 = BASE_DIV * 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dma_addr;
  logic [7:0]  dma_length;
  logic [7:0]  dma_ctrl;
  logic        trig_wr;
  logic [7:0]  trig_din;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] bus_addr;
  logic [2:0]  bus_bank;
  logic [7:0]  bus_din;
  logic [3:0]  sample;
  logic        sample_stb;
  logic        busy;
  logic        done;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          last_off = 0;
  logic [3:0]  stb_val[$];
  int          stb_cyc[$];
  logic [15:0] commit_log[$];
  int          done_n = 0;
  int          done_cyc = -1;
  logic        busy_at_done = 1'b1;

  audio_dma_reader #(.BASE_DIV(BASE_DIV), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .dma_addr(dma_addr), .dma_length(dma_length),
    .dma_ctrl(dma_ctrl), .trig_wr(trig_wr), .trig_din(trig_din),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr), .bus_bank(bus_bank),
    .bus_din(bus_din), .sample(sample), .sample_stb(sample_stb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  function automatic logic [3:0] exp_nib(input logic [15:0] base, input int i);
    logic [7:0] b;
    b = rom(base + 16'(i / 2));
    return (i % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  function automatic int count_bad(input logic [15:0] base, input int first, input int n);
    int bad = 0;
    for (int i = 0; i < n && (first + i) < stb_val.size(); i++)
      if (stb_val[first + i] !== exp_nib(base, i)) bad++;
    return bad;
  endfunction

  function automatic int count_gap_bad(input int per);
    int bad = 0;
    for (int i = 1; i < stb_cyc.size(); i++)
      if (stb_cyc[i] - stb_cyc[i-1] != per) bad++;
    return bad;
  endfunction

  // Memory model: a granted request returns ROM data for the following cycle
  always @(posedge clk) begin
    if (!reset && bus_req && bus_gnt) begin
      bus_din = rom(bus_addr);
      commit_log.push_back(bus_addr);
    end
  end

  task automatic step();
    @(negedge clk);
    cyc++;
    if (sample_stb) begin
      stb_val.push_back(sample);
      stb_cyc.push_back(cyc);
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
  endtask

  task automatic clear_log();
    stb_val.delete();
    stb_cyc.delete();
    commit_log.delete();
    done_n = 0;
    done_cyc = -1;
    busy_at_done = 1'b1;
  endtask

  task automatic start(input logic [15:0] a, input logic [7:0] len, input logic [7:0] ctrl);
    dma_addr = a;
    dma_length = len;
    dma_ctrl = ctrl;
    trig_wr = 1'b1;
    trig_din = 8'h80;
    step();
    trig_wr = 1'b0;
    trig_din = 8'h00;
    clear_log();
    start_cyc = cyc;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (done_n == 0 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b expected 0", bus_req); end
    checks++; if (bus_addr !== 16'h0000) begin errors++; $display("FAIL reset_bus_addr: got %h expected 0000", bus_addr); end
    checks++; if (bus_bank !== 3'd0) begin errors++; $display("FAIL reset_bus_bank: got %0d expected 0", bus_bank); end
    checks++; if (sample !== 4'h0) begin errors++; $display("FAIL reset_sample: got %h expected 0", sample); end
    checks++; if ({sample_stb, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {sample_stb, busy, done}); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int last;
    start(16'hC000, 8'd1, 8'h80);
    run_until_done(32 * PER0 * 2 + 100);
    last = (stb_cyc.size() > 0) ? stb_cyc[stb_cyc.size()-1] : -2;
    last_off = done_cyc - start_cyc;
    checks++; if (stb_val.size() !== 32) begin errors++; $display("FAIL basic_stb_count: got %0d expected 32", stb_val.size()); end
    checks++; if (count_bad(16'hC000, 0, 32) !== 0) begin errors++; $display("FAIL basic_nibbles: got %0d bad expected 0", count_bad(16'hC000, 0, 32)); end
    checks++; if (count_gap_bad(PER0) !== 0) begin errors++; $display("FAIL basic_spacing: got %0d bad gaps expected 0", count_gap_bad(PER0)); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_n); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %b expected 0", busy_at_done); end
    checks++; if (done_cyc !== last) begin errors++; $display("FAIL basic_done_with_last_stb: got %0d expected %0d", done_cyc, last); end
    repeat (20) step();
    checks++; if ({bus_req, busy, done_n} !== {1'b0, 1'b0, 32'd1}) begin errors++; $display("FAIL basic_idle_after: got req=%b busy=%b done_n=%0d expected 0 0 1", bus_req, busy, done_n); end
    checks++; if (sample !== exp_nib(16'hC000, 31)) begin errors++; $display("FAIL basic_sample_hold: got %h expected %h", sample, exp_nib(16'hC000, 31)); end
  endtask

  task automatic test_rate_bank();
    int n = 0;
    int bank_bad = 0;
    start(16'h8000, 8'd1, 8'hD3);
    while (done_n == 0 && n < 32 * PER3 + 200) begin
      step();
      n++;
      if (bus_req && bus_bank !== 3'd5) bank_bad++;
    end
    checks++; if (stb_val.size() !== 32) begin errors++; $display("FAIL rate3_stb_count: got %0d expected 32", stb_val.size()); end
    checks++; if (count_gap_bad(PER3) !== 0) begin errors++; $display("FAIL rate3_spacing: got %0d bad gaps expected 0", count_gap_bad(PER3)); end
    checks++; if (count_bad(16'h8000, 0, 32) !== 0) begin errors++; $display("FAIL rate3_nibbles: got %0d bad expected 0", count_bad(16'h8000, 0, 32)); end
    checks++; if (bank_bad !== 0) begin errors++; $display("FAIL bank_during_req: got %0d bad cycles expected 0", bank_bad); end
    checks++; if (bus_bank !== 3'd5) begin errors++; $display("FAIL bank_latched: got %0d expected 5", bus_bank); end
  endtask

  task automatic test_underrun();
    int n = 0;
    int seq_bad = 0;
    start(16'hC100, 8'd1, 8'h80);
    while (commit_log.size() == 0 && n < 50) begin
      step();
      n++;
    end
    bus_gnt = 1'b0;
    repeat (200) step();
    checks++; if (stb_val.size() !== 2) begin errors++; $display("FAIL underrun_stb_count: got %0d expected 2", stb_val.size()); end
    checks++; if (sample !== exp_nib(16'hC100, 1)) begin errors++; $display("FAIL underrun_sample_hold: got %h expected %h", sample, exp_nib(16'hC100, 1)); end
    checks++; if ({bus_req, bus_addr} !== {1'b1, 16'hC101}) begin errors++; $display("FAIL underrun_req_hold: got req=%b addr=%h expected 1 C101", bus_req, bus_addr); end
    checks++; if (commit_log.size() !== 1) begin errors++; $display("FAIL underrun_commits: got %0d expected 1", commit_log.size()); end
    bus_gnt = 1'b1;
    run_until_done(32 * PER0 * 2 + 200);
    for (int i = 0; i < commit_log.size(); i++)
      if (commit_log[i] !== 16'hC100 + 16'(i)) seq_bad++;
    checks++; if (stb_val.size() !== 32) begin errors++; $display("FAIL resume_stb_count: got %0d expected 32", stb_val.size()); end
    checks++; if (count_bad(16'hC100, 0, 32) !== 0) begin errors++; $display("FAIL resume_nibbles: got %0d bad expected 0", count_bad(16'hC100, 0, 32)); end
    checks++; if ({commit_log.size(), seq_bad} !== {32'd16, 32'd0}) begin errors++; $display("FAIL resume_addr_seq: got %0d commits %0d bad expected 16 0", commit_log.size(), seq_bad); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL resume_done: got %0d expected 1", done_n); end
  endtask

  task automatic test_restart();
    int n = 0;
    logic [15:0] first_addr;
    start(16'hC200, 8'd1, 8'h80);
    while (commit_log.size() < 5 && n < 200) begin
      step();
      n++;
    end
    checks++; if (done_n !== 0) begin errors++; $display("FAIL restart_no_early_done: got %0d expected 0", done_n); end
    start(16'hD000, 8'd1, 8'h80);
    checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL restart_flags: got done=%b busy=%b expected 0 1", done, busy); end
    run_until_done(32 * PER0 * 2 + 200);
    first_addr = (commit_log.size() > 0) ? commit_log[0] : 16'hDEAD;
    checks++; if (first_addr !== 16'hD000) begin errors++; $display("FAIL restart_first_addr: got %h expected D000", first_addr); end
    checks++; if (stb_val.size() !== 32) begin errors++; $display("FAIL restart_stb_count: got %0d expected 32", stb_val.size()); end
    checks++; if (count_bad(16'hD000, 0, 32) !== 0) begin errors++; $display("FAIL restart_nibbles: got %0d bad expected 0", count_bad(16'hD000, 0, 32)); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL restart_done: got %0d expected 1", done_n); end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    start(16'hC000, 8'd1, 8'h80);
    while (cyc - start_cyc < last_off - 1 && n < 1000) begin
      step();
      n++;
    end
    checks++; if (done_n !== 0) begin errors++; $display("FAIL simul_no_early_done: got %0d expected 0", done_n); end
    dma_addr = 16'hC300;
    trig_wr = 1'b1;
    trig_din = 8'h80;
    step();
    trig_wr = 1'b0;
    trig_din = 8'h00;
    checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL simul_restart_wins: got done=%b busy=%b expected 0 1", done, busy); end
    clear_log();
    run_until_done(32 * PER0 * 2 + 200);
    checks++; if (count_bad(16'hC300, 0, 32) !== 0) begin errors++; $display("FAIL simul_new_block: got %0d bad expected 0", count_bad(16'hC300, 0, 32)); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL simul_done_after: got %0d expected 1", done_n); end
  endtask

  task automatic test_stop();
    bus_gnt = 1'b0;
    start(16'hE000, 8'd1, 8'h80);
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL stop_pre_req: got %b expected 1", bus_req); end
    trig_wr = 1'b1;
    trig_din = 8'h00;
    step();
    trig_wr = 1'b0;
    checks++; if ({bus_req, busy, done} !== 3'b000) begin errors++; $display("FAIL stop_trig: got req/busy/done=%b expected 000", {bus_req, busy, done}); end
    bus_gnt = 1'b1;
    repeat (50) step();
    checks++; if ({done_n, stb_val.size(), commit_log.size()} !== {32'd0, 32'd0, 32'd0}) begin errors++; $display("FAIL stop_quiet: got done=%0d stb=%0d commits=%0d expected 0 0 0", done_n, stb_val.size(), commit_log.size()); end
    start(16'hE000, 8'd1, 8'h80);
    repeat (10) step();
    dma_ctrl = 8'h00;
    step();
    checks++; if ({bus_req, busy} !== 2'b00) begin errors++; $display("FAIL stop_ctrl: got req=%b busy=%b expected 0 0", bus_req, busy); end
    repeat (50) step();
    checks++; if (done_n !== 0) begin errors++; $display("FAIL stop_ctrl_no_done: got %0d expected 0", done_n); end
  endtask

  task automatic test_reset_mid();
    start(16'hC000, 8'd1, 8'h80);
    repeat (30) step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_pre_busy: got %b expected 1", busy); end
    reset = 1'b1;
    step();
    checks++; if ({bus_req, bus_addr, bus_bank, sample, sample_stb, busy, done} !== 27'd0) begin errors++; $display("FAIL midreset_outputs: got %h expected 0", {bus_req, bus_addr, bus_bank, sample, sample_stb, busy, done}); end
    reset = 1'b0;
    repeat (20) step();
    checks++; if ({done_n, busy} !== {32'd0, 1'b0}) begin errors++; $display("FAIL midreset_no_done: got done=%0d busy=%b expected 0 0", done_n, busy); end
  endtask

`ifdef AUDIO_DMA_LOOP_EN
  task automatic test_loop();
    int n = 0;
    int busy_low = 0;
    start(16'hC000, 8'd1, 8'h80);
    while (stb_val.size() < 64 && n < 64 * PER0 * 2 + 400) begin
      step();
      n++;
      if (!busy) busy_low++;
    end
    checks++; if (done_n !== 2) begin errors++; $display("FAIL loop_done_count: got %0d expected 2", done_n); end
    checks++; if (busy_low !== 0) begin errors++; $display("FAIL loop_busy_drop: got %0d cycles expected 0", busy_low); end
    checks++; if (count_bad(16'hC000, 32, 32) !== 0) begin errors++; $display("FAIL loop_second_pass: got %0d bad expected 0", count_bad(16'hC000, 32, 32)); end
    trig_wr = 1'b1;
    trig_din = 8'h00;
    step();
    trig_wr = 1'b0;
  endtask
`endif

  task automatic test_len0_wrap();
    logic [15:0] a0, a16, alast;
    start(16'hFFF0, 8'd0, 8'h80);
    run_until_done(8192 * PER0 + 2000);
    a0    = (commit_log.size() > 0)    ? commit_log[0]    : 16'hDEAD;
    a16   = (commit_log.size() > 16)   ? commit_log[16]   : 16'hDEAD;
    alast = (commit_log.size() > 4095) ? commit_log[4095] : 16'hDEAD;
    checks++; if (stb_val.size() !== 8192) begin errors++; $display("FAIL len0_stb_count: got %0d expected 8192", stb_val.size()); end
    checks++; if (commit_log.size() !== 4096) begin errors++; $display("FAIL len0_commits: got %0d expected 4096", commit_log.size()); end
    checks++; if (count_bad(16'hFFF0, 0, 8192) !== 0) begin errors++; $display("FAIL len0_nibbles: got %0d bad expected 0", count_bad(16'hFFF0, 0, 8192)); end
    checks++; if ({a0, a16, alast} !== {16'hFFF0, 16'h0000, 16'h0FEF}) begin errors++; $display("FAIL len0_wrap_addr: got %h %h %h expected FFF0 0000 0FEF", a0, a16, alast); end
    checks++; if (done_n !== 1) begin errors++; $display("FAIL len0_done: got %0d expected 1", done_n); end
  endtask

  initial begin
    reset = 1'b1;
    dma_addr = 16'h0000;
    dma_length = 8'd0;
    dma_ctrl = 8'h00;
    trig_wr = 1'b0;
    trig_din = 8'h00;
    bus_gnt = 1'b1;
    bus_din = 8'h00;
    test_reset();
    test_basic();
    test_rate_bank();
    test_underrun();
    test_restart();
    test_simultaneous();
    test_stop();
    test_reset_mid();
`ifdef AUDIO_DMA_LOOP_EN
    test_loop();
`endif
    test_len0_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
